// File: rtl/icache_refill.sv
// ---------------------------------------------------------------------------
// icache_refill -- instruction-cache line refill engine.
//
// After reset, sweeps every set of the tag/valid RAM to invalid, then serves
// misses one at a time: it captures the miss address, issues a line read,
// writes the eight returning 32-bit beats into the one-hot-selected data
// banks, forwards the critical word as it passes, and commits tag+valid in a
// final cycle.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   miss_valid/addr/ready lookup-side miss handshake
//   rd_req/addr/ready     line read request to the memory side
//   ret_valid/data/last   return beats, word 0 first
//   bank_we/waddr/wdata   data-bank write port (one-hot bank select)
//   tagv_we/waddr/wdata   tag/valid RAM write port {pad, tag, valid}
//   word_valid/data       critical-word forward
//   refill_done/err       one-cycle commit pulse and return-protocol error
//   init_done             invalidation sweep finished (held until reset)
// ---------------------------------------------------------------------------
module icache_refill #(
  parameter int INDEX_SIZE = 7,
  parameter int TAG_SIZE   = 20,
  parameter int BANK_NUM   = 8,
  parameter int SETSIZE    = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  miss_valid,
  input  logic [31:0]           miss_addr,
  output logic                  miss_ready,
  output logic                  rd_req,
  output logic [31:0]           rd_addr,
  input  logic                  rd_ready,
  input  logic                  ret_valid,
  input  logic [31:0]           ret_data,
  input  logic                  ret_last,
  output logic [BANK_NUM-1:0]   bank_we,
  output logic [INDEX_SIZE-1:0] bank_waddr,
  output logic [31:0]           bank_wdata,
  output logic                  tagv_we,
  output logic [INDEX_SIZE-1:0] tagv_waddr,
  output logic [31:0]           tagv_wdata,
  output logic                  word_valid,
  output logic [31:0]           word_data,
  output logic                  refill_done,
  output logic                  refill_err,
  output logic                  init_done
);

  localparam int BEAT_W = $clog2(BANK_NUM);

  localparam logic [2:0] S_INIT   = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_REQ    = 3'd2;
  localparam logic [2:0] S_RECV   = 3'd3;
  localparam logic [2:0] S_COMMIT = 3'd4;

  localparam logic [INDEX_SIZE-1:0] LAST_SET  = INDEX_SIZE'(SETSIZE - 1);
  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BANK_NUM - 1);

  logic [2:0]            state_q, state_d;
  logic [INDEX_SIZE-1:0] sweep_q, sweep_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [TAG_SIZE-1:0]   tag_q, tag_d;
  logic [INDEX_SIZE-1:0] index_q, index_d;
  logic [BEAT_W-1:0]     offs_q, offs_d;
  logic                  err_q, err_d;
  logic                  init_done_q, init_done_d;

  // Byte-offset bits never matter for a word-granular line refill.
  logic unused_addr_bits;
  assign unused_addr_bits = ^miss_addr[1:0];

  // Next-state logic.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    sweep_d     = sweep_q;
    beat_d      = beat_q;
    tag_d       = tag_q;
    index_d     = index_q;
    offs_d      = offs_q;
    err_d       = err_q;
    init_done_d = init_done_q;

    case (state_q)
      S_INIT: begin
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == LAST_SET) begin
          state_d     = S_IDLE;
          init_done_d = 1'b1;
        end
      end
      S_IDLE: begin
        // miss_ready is 1 in IDLE, so miss_valid alone completes the handshake.
        if (miss_valid) begin
          tag_d   = miss_addr[31 -: TAG_SIZE];
          index_d = miss_addr[5 +: INDEX_SIZE];
          offs_d  = miss_addr[2 +: BEAT_W];
          err_d   = 1'b0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (rd_ready) begin
          beat_d  = '0;
          state_d = S_RECV;
        end
      end
      S_RECV: begin
        if (ret_valid) begin
          beat_d = beat_q + 1'b1;
          // ret_last must coincide exactly with the final beat; the beat
          // count, not ret_last, decides when the line is complete.
          if (ret_last != (beat_q == LAST_BEAT)) err_d = 1'b1;
          if (beat_q == LAST_BEAT) state_d = S_COMMIT;
        end
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_INIT;
    endcase
  end

  // Output decode. Everything is forced low while reset is asserted so an
  // in-flight refill is abandoned immediately and nothing is committed.
  always_comb begin
    miss_ready  = 1'b0;
    rd_req      = 1'b0;
    rd_addr     = '0;
    bank_we     = '0;
    bank_waddr  = '0;
    bank_wdata  = '0;
    tagv_we     = 1'b0;
    tagv_waddr  = '0;
    tagv_wdata  = '0;
    word_valid  = 1'b0;
    word_data   = '0;
    refill_done = 1'b0;
    refill_err  = 1'b0;

    if (!reset) begin
      case (state_q)
        S_INIT: begin
          tagv_we    = 1'b1;
          tagv_waddr = sweep_q;
        end
        S_IDLE: miss_ready = 1'b1;
        S_REQ: begin
          rd_req  = 1'b1;
          rd_addr = {tag_q, index_q, 5'b0};
        end
        S_RECV: begin
          if (ret_valid) begin
            bank_we    = {{(BANK_NUM-1){1'b0}}, 1'b1} << beat_q;
            bank_waddr = index_q;
            bank_wdata = ret_data;
            if (beat_q == offs_q) begin
              word_valid = 1'b1;
              word_data  = ret_data;
            end
          end
        end
        S_COMMIT: begin
          tagv_we     = 1'b1;
          tagv_waddr  = index_q;
          tagv_wdata  = {{(31-TAG_SIZE){1'b0}}, tag_q, 1'b1};
          refill_done = 1'b1;
          refill_err  = err_q;
        end
        default: ;
      endcase
    end
  end

  assign init_done = init_done_q & ~reset;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_INIT;
      sweep_q     <= '0;
      beat_q      <= '0;
      tag_q       <= '0;
      index_q     <= '0;
      offs_q      <= '0;
      err_q       <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      beat_q      <= beat_d;
      tag_q       <= tag_d;
      index_q     <= index_d;
      offs_q      <= offs_d;
      err_q       <= err_d;
      init_done_q <= init_done_d;
    end
  end

endmodule
